// File: rtl/datapath_pkg.sv
// Shared datapath types for the GEMM functional-unit status table (FUST-G).
// Holds the row payload, FUST row view, scheduler state encoding and tag helpers.
package datapath_pkg;

  localparam int unsigned TAG_W = 2;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_READY = '0;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rc;
    logic [7:0] imm;
  } fust_g_row_t;

  typedef struct packed {
    fust_g_row_t row;
    tag_t        t1;
    tag_t        t2;
    tag_t        t3;
    logic        busy;
  } fust_g_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    ISSUE,
    EXEC
  } gemm_fust_state_t;

  // A held tag clears only on an exact match with a real (nonzero) writeback tag.
  function automatic tag_t snoop_clear(tag_t t, logic wb_valid, tag_t wb_tag);
    return (wb_valid && (wb_tag != TAG_READY) && (t == wb_tag)) ? TAG_READY : t;
  endfunction

endpackage

// File: rtl/gemm_tag_snoop.sv
// Combinational writeback snoop for three source tags; shared by the dispatch
// capture bypass and the operand-wait update.
module gemm_tag_snoop
  import datapath_pkg::*;
(
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [TAG_W-1:0] t1,
  input  logic [TAG_W-1:0] t2,
  input  logic [TAG_W-1:0] t3,
  output logic [TAG_W-1:0] c1,
  output logic [TAG_W-1:0] c2,
  output logic [TAG_W-1:0] c3,
  output logic             all_ready
);

  assign c1 = snoop_clear(t1, wb_valid, wb_tag);
  assign c2 = snoop_clear(t2, wb_valid, wb_tag);
  assign c3 = snoop_clear(t3, wb_valid, wb_tag);

  assign all_ready = (c1 == TAG_READY) && (c2 == TAG_READY) && (c3 == TAG_READY);

endmodule

// File: rtl/gemm_fust_sched.sv
// Single-row GEMM FUST scheduler: capture, operand wait, issue handshake, execute.
// Optional completion watchdog enabled by GEMM_FUST_TIMEOUT_EN.
module gemm_fust_sched
  import datapath_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_en,
  input  fust_g_row_t      disp_row,
  input  logic [TAG_W-1:0] disp_t1,
  input  logic [TAG_W-1:0] disp_t2,
  input  logic [TAG_W-1:0] disp_t3,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  input  logic             gemm_ready,
  input  logic             gemm_done,
  output logic             fust_busy,
  output fust_g_t          fust,
  output logic             issue_valid,
  output fust_g_row_t      issue_row,
  output logic             cmpl_valid,
  output logic             cmpl_squash,
  output logic             err_timeout
);

  gemm_fust_state_t state, state_d;
  fust_g_row_t      row, row_d;
  tag_t             t1, t2, t3, t1_d, t2_d, t3_d;
  tag_t             s1, s2, s3;
  logic             all_ready;
  logic             squash, squash_d;
  logic             cmpl_valid_d, cmpl_squash_d;
  logic             timeout_hit;
  logic             idle;

  assign idle = (state == IDLE);

  // While idle the snoop sees the incoming tags (capture bypass), otherwise the held ones.
  gemm_tag_snoop u_snoop (
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .t1        (idle ? disp_t1 : t1),
    .t2        (idle ? disp_t2 : t2),
    .t3        (idle ? disp_t3 : t3),
    .c1        (s1),
    .c2        (s2),
    .c3        (s3),
    .all_ready (all_ready)
  );

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin : next_state
    state_d = state;
    case (state)
      IDLE:     if (disp_en && !flush) state_d = all_ready ? ISSUE : WAIT_OPS;
      WAIT_OPS: if (flush) state_d = IDLE;
                else if (all_ready) state_d = ISSUE;
      // An accepted handshake cannot be taken back; a coincident flush becomes a squash.
      ISSUE:    if (gemm_ready) state_d = EXEC;
                else if (flush) state_d = IDLE;
      EXEC:     if (gemm_done || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin : out_comb
    row_d         = row;
    t1_d          = t1;
    t2_d          = t2;
    t3_d          = t3;
    squash_d      = squash;
    cmpl_valid_d  = 1'b0;
    cmpl_squash_d = 1'b0;
    case (state)
      IDLE: if (disp_en && !flush) begin
        row_d    = disp_row;
        t1_d     = s1;
        t2_d     = s2;
        t3_d     = s3;
        squash_d = 1'b0;
      end
      WAIT_OPS: begin
        t1_d = s1;
        t2_d = s2;
        t3_d = s3;
        if (flush) begin
          row_d = '0;
          t1_d  = TAG_READY;
          t2_d  = TAG_READY;
          t3_d  = TAG_READY;
        end
      end
      ISSUE: begin
        if (gemm_ready) squash_d = flush;
        else if (flush) row_d = '0;
      end
      EXEC: begin
        if (flush) squash_d = 1'b1;
        if (gemm_done || timeout_hit) begin
          cmpl_valid_d  = 1'b1;
          cmpl_squash_d = squash | flush | timeout_hit;
          row_d         = '0;
          squash_d      = 1'b0;
        end
      end
      default: row_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : data_reg
    if (rst) begin
      row         <= '0;
      t1          <= TAG_READY;
      t2          <= TAG_READY;
      t3          <= TAG_READY;
      squash      <= 1'b0;
      cmpl_valid  <= 1'b0;
      cmpl_squash <= 1'b0;
    end else begin
      row         <= row_d;
      t1          <= t1_d;
      t2          <= t2_d;
      t3          <= t3_d;
      squash      <= squash_d;
      cmpl_valid  <= cmpl_valid_d;
      cmpl_squash <= cmpl_squash_d;
    end
  end

`ifdef GEMM_FUST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Counts EXEC cycles; fires in the TIMEOUT-th EXEC cycle if no done arrived.
  assign timeout_hit = (state == EXEC) && !gemm_done && ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin : watchdog
    if (rst) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state == EXEC) ? cnt + CNT_W'(1) : '0;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign fust_busy   = !idle;
  assign issue_valid = (state == ISSUE);
  assign issue_row   = issue_valid ? row : '0;
  assign fust        = '{row: row, t1: t1, t2: t2, t3: t3, busy: !idle};

  a_timeout_cfg: assert property (@(posedge clk) TIMEOUT > 0);
  a_disp_idle:   assert property (@(posedge clk) disable iff (rst) disp_en |-> idle);
  a_done_exec:   assert property (@(posedge clk) disable iff (rst) gemm_done |-> (state == EXEC));
  a_issue_hold:  assert property (@(posedge clk) disable iff (rst)
                   (issue_valid && !gemm_ready && !flush) |=> (issue_valid && $stable(issue_row)));

endmodule

// File: tb/tb_gemm_fust_sched.sv
// Randomized + directed bench for gemm_fust_sched against a transaction-level row model.
module tb_gemm_fust_sched;
  import datapath_pkg::*;

`ifdef GEMM_FUST_TIMEOUT_EN
  localparam int unsigned TMO   = 8;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TMO   = 1024;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        clk, rst, disp_en, wb_valid, flush, gemm_ready, gemm_done;
  fust_g_row_t disp_row, issue_row;
  logic [1:0]  disp_t1, disp_t2, disp_t3, wb_tag;
  logic        fust_busy, issue_valid, cmpl_valid, cmpl_squash, err_timeout;
  fust_g_t     fust;

  gemm_fust_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en), .disp_row(disp_row),
    .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_t3(disp_t3),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
    .gemm_ready(gemm_ready), .gemm_done(gemm_done),
    .fust_busy(fust_busy), .fust(fust), .issue_valid(issue_valid),
    .issue_row(issue_row), .cmpl_valid(cmpl_valid), .cmpl_squash(cmpl_squash),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model: is an instruction held, has it been handed to the unit, which sources still wait.
  bit          occ, iss, sq, m_cv, m_cs, m_err;
  fust_g_row_t m_row;
  logic [1:0]  mt [3];
  int          exec_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] wb_clear(input logic [1:0] t);
    if (wb_valid && wb_tag != 2'd0 && t == wb_tag) return 2'd0;
    return t;
  endfunction

  task automatic model_drop();
    occ = 0; iss = 0; sq = 0; m_row = '0; exec_n = 0;
    for (int i = 0; i < 3; i++) mt[i] = 2'd0;
  endtask

  task automatic model_reset();
    model_drop();
    m_cv = 0; m_cs = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit waiting;
    m_cv = 0; m_cs = 0;
    waiting = (mt[0] != 0) || (mt[1] != 0) || (mt[2] != 0);
    if (!occ) begin
      if (disp_en && !flush) begin
        occ = 1; iss = 0; sq = 0; m_row = disp_row;
        mt[0] = wb_clear(disp_t1); mt[1] = wb_clear(disp_t2); mt[2] = wb_clear(disp_t3);
      end
    end else if (!iss) begin
      if (waiting) begin
        if (flush) model_drop();
        else for (int i = 0; i < 3; i++) mt[i] = wb_clear(mt[i]);
      end else if (gemm_ready) begin
        iss = 1; sq = flush; exec_n = 0;
      end else if (flush) model_drop();
    end else begin
      exec_n++;
      if (flush) sq = 1;
      if (gemm_done || (TO_EN && exec_n == int'(TMO))) begin
        m_cv = 1;
        m_cs = sq || !gemm_done;
        if (!gemm_done) m_err = 1;
        model_drop();
      end
    end
  endtask

  task automatic compare_all();
    fust_g_t e;
    logic [$bits(fust_g_t)-1:0] fa, fe;
    bit ev;
    ev = occ && !iss && mt[0] == 0 && mt[1] == 0 && mt[2] == 0;
    e.row = m_row; e.t1 = mt[0]; e.t2 = mt[1]; e.t3 = mt[2]; e.busy = occ;
    fa = fust; fe = e;
    chk("fust_busy", 64'(fust_busy), 64'(occ));
    chk("fust", 64'(fa), 64'(fe));
    chk("issue_valid", 64'(issue_valid), 64'(ev));
    chk("issue_row", 64'(issue_row), ev ? 64'(m_row) : 64'd0);
    chk("cmpl_valid", 64'(cmpl_valid), 64'(m_cv));
    chk("cmpl_squash", 64'(cmpl_squash), 64'(m_cs));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
  endtask

  task automatic clear_in();
    disp_en = 0; disp_row = '0; disp_t1 = 0; disp_t2 = 0; disp_t3 = 0;
    wb_valid = 0; wb_tag = 0; flush = 0; gemm_ready = 0; gemm_done = 0;
  endtask

  // Inputs are set at a negedge; apply one edge, then check at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    clear_in();
  endtask

  fust_g_row_t r1, r2, r3;

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    r1 = fust_g_row_t'(32'hA5C3_0F11);
    r2 = fust_g_row_t'(32'h1234_5678);
    r3 = fust_g_row_t'(32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    chk("reset_busy", 64'(fust_busy), 64'd0);
    rst = 1'b0;

    // Ready operands: issue next cycle, exec after handshake, done 5 cycles later.
    disp_en = 1; disp_row = r1; gemm_ready = 1; tick();
    chk("rdy_issue_valid", 64'(issue_valid), 64'd1);
    chk("rdy_issue_row", 64'(issue_row), 64'(r1));
    gemm_ready = 1; tick();
    chk("rdy_exec_busy", 64'(fust_busy), 64'd1);
    chk("rdy_exec_iv", 64'(issue_valid), 64'd0);
    repeat (4) tick();
    gemm_done = 1; tick();
    chk("rdy_cmpl", 64'(cmpl_valid), 64'd1);
    chk("rdy_cmpl_sq", 64'(cmpl_squash), 64'd0);
    chk("rdy_idle", 64'(fust_busy), 64'd0);
    tick();
    chk("rdy_cmpl_pulse", 64'(cmpl_valid), 64'd0);

    // Tag wait with an unrelated writeback in between.
    disp_en = 1; disp_row = r2; disp_t1 = 2; disp_t2 = 3; tick();
    chk("wait_t1", 64'(fust.t1), 64'd2);
    chk("wait_iv0", 64'(issue_valid), 64'd0);
    wb_valid = 1; wb_tag = 1; tick();
    chk("wait_wb1_t1", 64'(fust.t1), 64'd2);
    chk("wait_wb1_t2", 64'(fust.t2), 64'd3);
    wb_valid = 1; wb_tag = 3; tick();
    chk("wait_wb3_t2", 64'(fust.t2), 64'd0);
    chk("wait_wb3_iv", 64'(issue_valid), 64'd0);
    wb_valid = 1; wb_tag = 2; tick();
    chk("wait_issue", 64'(issue_valid), 64'd1);
    gemm_ready = 1; tick();
    gemm_done = 1; tick();

    // Capture bypass, then backpressure.
    disp_en = 1; disp_row = r3; disp_t2 = 1; wb_valid = 1; wb_tag = 1; tick();
    chk("byp_t2", 64'(fust.t2), 64'd0);
    chk("byp_iv", 64'(issue_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_iv", 64'(issue_valid), 64'd1);
      chk("bp_row", 64'(issue_row), 64'(r3));
    end
    gemm_ready = 1; tick();
    chk("bp_done_iv", 64'(issue_valid), 64'd0);
    flush = 1; tick();
    chk("exfl_busy", 64'(fust_busy), 64'd1);
    gemm_done = 1; tick();
    chk("exfl_cmpl", 64'(cmpl_valid), 64'd1);
    chk("exfl_sq", 64'(cmpl_squash), 64'd1);

    // Flush in operand wait, flush in issue, flush racing dispatch.
    disp_en = 1; disp_row = r1; disp_t1 = 1; tick();
    flush = 1; tick();
    chk("wfl_busy", 64'(fust_busy), 64'd0);
    chk("wfl_iv", 64'(issue_valid), 64'd0);
    disp_en = 1; disp_row = r2; tick();
    flush = 1; tick();
    chk("ifl_iv", 64'(issue_valid), 64'd0);
    disp_en = 1; disp_row = r3; flush = 1; tick();
    chk("dfl_busy", 64'(fust_busy), 64'd0);

    // Reset during EXEC; the stale done arrives while reset is held.
    disp_en = 1; disp_row = r1; tick();
    gemm_ready = 1; tick();
    rst = 1; gemm_done = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_cmpl", 64'(cmpl_valid), 64'd0);
    rst = 0; gemm_done = 0;
    tick();
    chk("rst_after", 64'(fust_busy), 64'd0);

`ifdef GEMM_FUST_TIMEOUT_EN
    disp_en = 1; disp_row = r2; tick();
    gemm_ready = 1; tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) chk("to_pre", 64'(err_timeout), 64'd0);
    end
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_cmpl", 64'(cmpl_valid), 64'd1);
    chk("to_sq", 64'(cmpl_squash), 64'd1);
    chk("to_idle", 64'(fust_busy), 64'd0);
`else
    chk("no_to_err", 64'(err_timeout), 64'd0);
`endif

    // Randomized traffic obeying the dispatch and done protocols.
    for (int i = 0; i < 1500; i++) begin
      disp_en    = !occ && ($urandom_range(0, 1) == 1);
      disp_row   = fust_g_row_t'($urandom());
      disp_t1    = 2'($urandom_range(0, 3));
      disp_t2    = 2'($urandom_range(0, 3));
      disp_t3    = 2'($urandom_range(0, 3));
      wb_valid   = ($urandom_range(0, 1) == 1);
      wb_tag     = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 19) == 0);
      gemm_ready = ($urandom_range(0, 9) < 6);
      gemm_done  = occ && iss && ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
